// File: rtl/dlatch_input_conditioner.sv
// rtl/dlatch_input_conditioner.sv - pad synchroniser, data register and enable debouncer
// Feeds the D-latch core a registered data bus plus a debounced enable with edge strobes.
module dlatch_input_conditioner #(
  parameter int WIDTH       = 7,
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] d_raw,
  input  logic             en_raw,
  output logic [WIDTH-1:0] d_clean,
  output logic             en_level,
  output logic             en_rise,
  output logic             en_fall,
  output logic             db_busy
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  // Enable rides as the top bit of each synchroniser word so both share one chain.
  logic [SYNC_STAGES-1:0][WIDTH:0] sync_q;
  logic [WIDTH-1:0]                d_sync;
  logic                            en_sync;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             fall_next;
  logic [WIDTH-1:0] d_next;
  db_state_e        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {en_raw, d_raw}};
    end
  end

  assign d_sync  = sync_q[SYNC_STAGES-1][WIDTH-1:0];
  assign en_sync = sync_q[SYNC_STAGES-1][WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      en_level <= 1'b0;
      en_rise  <= 1'b0;
      en_fall  <= 1'b0;
      db_busy  <= 1'b0;
      d_clean  <= '0;
    end else begin
      cnt      <= cnt_next;
      en_level <= level_next;
      en_rise  <= rise_next;
      en_fall  <= fall_next;
      db_busy  <= (cnt_next != '0);
      d_clean  <= d_next;
    end
  end

  // Phase is implied by whether the synchronised pin disagrees with the accepted level.
  always_comb begin
    state = (en_sync != en_level) ? COUNTING : IDLE;
  end

  always_comb begin
    cnt_next   = cnt;
    level_next = en_level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    d_next     = d_clean;
    if (ena) begin
      d_next = d_sync;
      case (state)
        IDLE: begin
          cnt_next = '0;
        end
        COUNTING: begin
          // Terminal compare comes before the increment, so cnt never wraps.
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            level_next = en_sync;
            rise_next  = en_sync;
            fall_next  = ~en_sync;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlatch_input_conditioner.sv
// tb/tb_dlatch_input_conditioner.sv - self-checking bench for dlatch_input_conditioner
module tb_dlatch_input_conditioner;

  localparam int WIDTH = 7;
  localparam int DB    = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic [WIDTH-1:0] d_raw = '0;
  logic             en_raw = 1'b0;
  logic [WIDTH-1:0] d_clean;
  logic             en_level;
  logic             en_rise;
  logic             en_fall;
  logic             db_busy;

  int tests = 0;
  int fails = 0;

  // Reference model: pins delayed through queues, debounce as a run length of disagreeing cycles.
  bit               en_q[$];
  logic [WIDTH-1:0] d_q[$];
  int               m_run;
  bit               m_level;
  bit               m_rise;
  bit               m_fall;
  logic [WIDTH-1:0] m_dclean;

  dlatch_input_conditioner #(
    .WIDTH(WIDTH),
    .DB_CYCLES(DB),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .d_raw(d_raw),
    .en_raw(en_raw),
    .d_clean(d_clean),
    .en_level(en_level),
    .en_rise(en_rise),
    .en_fall(en_fall),
    .db_busy(db_busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    en_q = {};
    d_q  = {};
    for (int i = 0; i < SYNC; i++) begin
      en_q.push_back(1'b0);
      d_q.push_back('0);
    end
    m_run    = 0;
    m_level  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_dclean = '0;
  endtask

  task automatic step();
    bit               old_en;
    logic [WIDTH-1:0] old_d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      old_en = en_q[SYNC-1];
      old_d  = d_q[SYNC-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (ena) begin
        m_dclean = old_d;
        if (old_en != m_level) begin
          m_run++;
          if (m_run == DB) begin
            m_level = old_en;
            m_run   = 0;
            m_rise  = old_en;
            m_fall  = !old_en;
          end
        end else begin
          m_run = 0;
        end
      end
      en_q.push_front(en_raw);
      void'(en_q.pop_back());
      d_q.push_front(d_raw);
      void'(d_q.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en_raw = 1'b1;
    d_raw  = 7'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({d_clean, en_level, en_rise, en_fall, db_busy} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got d_clean=%h lvl=%b rise=%b fall=%b busy=%b, required all 0",
                 d_clean, en_level, en_rise, en_fall, db_busy);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 2 || e == 3) begin
        tests++;
        if (d_clean !== ((e == 3) ? 7'h55 : 7'h00)) begin
          fails++;
          $display("FAIL reset_release_d_clean edge %0d: got %h required %h", e, d_clean,
                   (e == 3) ? 7'h55 : 7'h00);
        end
      end
      if (e >= 5) begin
        tests++;
        if (en_level !== (e >= 6) || en_rise !== (e == 6)) begin
          fails++;
          $display("FAIL reset_release_enable edge %0d: got lvl=%b rise=%b required lvl=%b rise=%b",
                   e, en_level, en_rise, e >= 6, e == 6);
        end
      end
    end
    en_raw = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    bit saw_rise = 1'b0;
    bit saw_lvl  = 1'b0;
    en_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) en_raw = 1'b0;
      step();
      saw_busy |= db_busy;
      saw_rise |= en_rise;
      saw_lvl  |= en_level;
    end
    tests++;
    if (saw_busy !== 1'b1 || saw_rise !== 1'b0 || saw_lvl !== 1'b0 || db_busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_reject: got busy_seen=%b rise_seen=%b lvl_seen=%b busy_end=%b required 1 0 0 0",
               saw_busy, saw_rise, saw_lvl, db_busy);
    end
  endtask

  task automatic test_clean_toggle();
    int rise_edge = -1;
    int fall_edge = -1;
    int n_rise = 0;
    int n_fall = 0;
    en_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (en_rise) begin n_rise++; if (rise_edge < 0) rise_edge = e; end
      if (en_fall) n_fall++;
    end
    en_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (en_fall) begin n_fall++; if (fall_edge < 0) fall_edge = e; end
      if (en_rise) n_rise++;
    end
    tests++;
    if (rise_edge != 6 || n_rise != 1) begin
      fails++;
      $display("FAIL toggle_rise: got edge=%0d count=%0d required edge=6 count=1", rise_edge, n_rise);
    end
    tests++;
    if (fall_edge != 6 || n_fall != 1) begin
      fails++;
      $display("FAIL toggle_fall: got edge=%0d count=%0d required edge=6 count=1", fall_edge, n_fall);
    end
  endtask

  task automatic test_data_latency();
    logic [WIDTH-1:0] exp_seq [1:5] = '{7'h00, 7'h00, 7'h2A, 7'h7F, 7'h7F};
    d_raw = 7'h00;
    repeat (4) step();
    for (int e = 1; e <= 5; e++) begin
      if (e == 1) d_raw = 7'h2A;
      if (e == 2) d_raw = 7'h7F;
      step();
      tests++;
      if (d_clean !== exp_seq[e]) begin
        fails++;
        $display("FAIL data_latency edge %0d: got %h required %h", e, d_clean, exp_seq[e]);
      end
    end
  endtask

  task automatic test_ena_freeze();
    bit bad = 1'b0;
    en_raw = 1'b1;
    repeat (4) step();
    tests++;
    if (db_busy !== 1'b1 || en_level !== 1'b0) begin
      fails++;
      $display("FAIL freeze_precondition: got busy=%b lvl=%b required busy=1 lvl=0", db_busy, en_level);
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (db_busy !== 1'b1 || en_rise !== 1'b0 || en_level !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL freeze_hold: got busy=%b rise=%b lvl=%b at end, required 1 0 0 throughout",
               db_busy, en_rise, en_level);
    end
    ena = 1'b1;
    step();
    tests++;
    if (en_level !== 1'b0 || en_rise !== 1'b0) begin
      fails++;
      $display("FAIL freeze_resume_1: got lvl=%b rise=%b required 0 0", en_level, en_rise);
    end
    step();
    tests++;
    if (en_level !== 1'b1 || en_rise !== 1'b1) begin
      fails++;
      $display("FAIL freeze_resume_2: got lvl=%b rise=%b required 1 1", en_level, en_rise);
    end
    en_raw = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_async_reset();
    int rise_edge = -1;
    int n_rise = 0;
    en_raw = 1'b1;
    repeat (5) step();
    tests++;
    if (db_busy !== 1'b1) begin
      fails++;
      $display("FAIL async_precondition: got busy=%b required 1", db_busy);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (db_busy !== 1'b0 || en_level !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_drop: got busy=%b lvl=%b required 0 0", db_busy, en_level);
    end
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (en_rise) begin n_rise++; if (rise_edge < 0) rise_edge = e; end
    end
    tests++;
    if (rise_edge != 6 || n_rise != 1) begin
      fails++;
      $display("FAIL async_requalify: got edge=%0d count=%0d required edge=6 count=1", rise_edge, n_rise);
    end
    en_raw = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_random();
    int hold = 0;
    logic [WIDTH+3:0] got;
    logic [WIDTH+3:0] exp;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        en_raw = ~en_raw;
        hold   = $urandom_range(1, 8);
      end
      hold--;
      d_raw = WIDTH'($urandom);
      ena   = ($urandom_range(0, 9) != 0);
      step();
      got = {d_clean, en_level, en_rise, en_fall, db_busy};
      exp = {m_dclean, m_level, m_rise, m_fall, (m_run != 0)};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_cycle %0d: got {d,lvl,rise,fall,busy}=%h required %h", i, got, exp);
      end
    end
    ena = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_clean_toggle();
    test_data_latency();
    test_ena_freeze();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
